// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared types and constants for the HPS ioctl download transmitter.
//   ioctl_state_e   transmitter FSM states
//   IOCTL_ADDR_W    default address/length width
//   IOCTL_IDX_*     image indices matching the core's bios/cart download split
//   DLY_W           width of the shared LEAD/GAP/TAIL delay counter
package ioctl_pkg;

   localparam int IOCTL_ADDR_W = 25;
   localparam int DLY_W        = 8;

   localparam logic [7:0] IOCTL_IDX_BIOS = 8'd0;
   localparam logic [7:0] IOCTL_IDX_CART = 8'd1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_FETCH = 3'd2,
      ST_WRITE = 3'd3,
      ST_GAP   = 3'd4,
      ST_TAIL  = 3'd5
   } ioctl_state_e;

endpackage

// File: rtl/ioctl_tx_if.sv
// ioctl_tx_if: ioctl download bus between the transmitter (master) and the core (slave).
//   ioctl_download  transfer-active envelope        (master -> slave)
//   ioctl_wr        one-cycle write strobe          (master -> slave)
//   ioctl_addr      byte address, ADDR_W bits       (master -> slave)
//   ioctl_dout      byte data                       (master -> slave)
//   ioctl_index     image index                     (master -> slave)
//   ioctl_wait      core back-pressure              (slave -> master)
interface ioctl_tx_if
   import ioctl_pkg::*;
#(
   parameter int ADDR_W = IOCTL_ADDR_W
);
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      output ioctl_wait
   );
endinterface

// File: rtl/ioctl_delay_cnt.sv
// ioctl_delay_cnt: loadable down-counter with zero flag, shared by the LEAD,
// GAP and TAIL phases of the transmitter.
//   clk_sys   clock
//   reset     synchronous active-high reset (count -> 0)
//   load      load load_val this cycle
//   load_val  count to load; a phase loaded with N-1 lasts N cycles
//   zero      count is zero (last cycle of the phase)
module ioctl_delay_cnt #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (reset)            cnt <= '0;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/ioctl_tx.sv
// ioctl_tx: transmitter side of the HPS ioctl download protocol. Pulls bytes
// from a valid/ready stream and writes them into a core over the ioctl bus,
// honouring ioctl_wait.
//   clk_sys, reset   clock, synchronous active-high reset
//   start            request a transfer (ignored unless idle)
//   index, length    image index and byte count, latched on accepted start
//   src_valid/src_data/src_ready  byte source; consumed on valid & ready
//   busy             high outside IDLE
//   done             one-cycle pulse when ioctl_download falls
//   io               ioctl bus (master modport)
//   checksum         mod-256 sum of written bytes, only with IOCTL_TX_CHECKSUM_EN
// Optional feature macro: IOCTL_TX_CHECKSUM_EN
module ioctl_tx
   import ioctl_pkg::*;
#(
   parameter int ADDR_W   = IOCTL_ADDR_W,
   parameter int WR_GAP   = 3,
   parameter int LEAD_CYC = 2,
   parameter int TAIL_CYC = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        index,
   input  logic [ADDR_W-1:0] length,
   input  logic              src_valid,
   input  logic [7:0]        src_data,
   output logic              src_ready,
   output logic              busy,
   output logic              done,
   ioctl_tx_if.master        io
`ifdef IOCTL_TX_CHECKSUM_EN
   ,
   output logic [7:0]        checksum
`endif
);
   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_LEAD  = ST_LEAD;
   localparam logic [2:0] S_FETCH = ST_FETCH;
   localparam logic [2:0] S_WRITE = ST_WRITE;
   localparam logic [2:0] S_GAP   = ST_GAP;
   localparam logic [2:0] S_TAIL  = ST_TAIL;

   // Phases last N cycles when the counter is loaded with N-1.
   localparam logic [DLY_W-1:0] LEAD_V = DLY_W'(LEAD_CYC - 1);
   localparam logic [DLY_W-1:0] GAP_V  = DLY_W'(WR_GAP - 1);
   localparam logic [DLY_W-1:0] TAIL_V = DLY_W'(TAIL_CYC - 1);

   logic [2:0]        state, state_nxt;
   logic [ADDR_W-1:0] len_q, cnt, cnt_inc, addr_q;
   logic [7:0]        idx_q, dout_q;
   logic              done_q, accept, fetch_go;
   logic              dly_load, dly_zero;
   logic [DLY_W-1:0]  dly_val;

   assign accept   = (state == S_IDLE) && start;
   assign fetch_go = (state == S_FETCH) && src_valid && !io.ioctl_wait;
   // cnt < len_q <= 2^ADDR_W-1 whenever this is used, so it cannot wrap.
   assign cnt_inc  = cnt + ADDR_W'(1);

   always_comb begin
      state_nxt = state;
      dly_load  = 1'b0;
      dly_val   = TAIL_V;
      case (state)
         S_IDLE:
            if (start) begin
               state_nxt = S_LEAD;
               dly_load  = 1'b1;
               dly_val   = LEAD_V;
            end
         S_LEAD:
            if (dly_zero) begin
               if (len_q == '0) begin
                  state_nxt = S_TAIL;
                  dly_load  = 1'b1;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         S_FETCH:
            if (fetch_go) state_nxt = S_WRITE;
         S_WRITE:
            if (WR_GAP != 0) begin
               state_nxt = S_GAP;
               dly_load  = 1'b1;
               dly_val   = GAP_V;
            end else if (cnt_inc == len_q) begin
               // no gap: apply the gap exit rule with the incremented count
               state_nxt = S_TAIL;
               dly_load  = 1'b1;
            end else begin
               state_nxt = S_FETCH;
            end
         S_GAP:
            if (dly_zero) begin
               if (cnt == len_q) begin
                  state_nxt = S_TAIL;
                  dly_load  = 1'b1;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         S_TAIL:
            if (dly_zero) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state  <= S_IDLE;
         len_q  <= '0;
         cnt    <= '0;
         addr_q <= '0;
         dout_q <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == S_TAIL) && dly_zero;
         if (accept) begin
            idx_q <= index;
            len_q <= length;
            cnt   <= '0;
         end
         // addr/dout only change on capture, so they hold through WRITE and GAP
         if (fetch_go) begin
            addr_q <= cnt;
            dout_q <= src_data;
         end
         if (state == S_WRITE) cnt <= cnt_inc;
      end
   end

   ioctl_delay_cnt #(.W(DLY_W)) u_dly (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .load     (dly_load),
      .load_val (dly_val),
      .zero     (dly_zero)
   );

`ifdef IOCTL_TX_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk_sys) begin
      if (reset)               csum <= '0;
      else if (accept)         csum <= '0;
      else if (state == S_WRITE) csum <= csum + dout_q;
   end

   assign checksum = csum;
`endif

   assign src_ready         = fetch_go;
   assign busy              = (state != S_IDLE);
   assign done              = done_q;
   assign io.ioctl_download = busy;
   assign io.ioctl_wr       = (state == S_WRITE);
   assign io.ioctl_addr     = addr_q;
   assign io.ioctl_dout     = dout_q;
   assign io.ioctl_index    = idx_q;
endmodule

// File: tb/tb_ioctl_tx.sv
// tb_ioctl_tx: self-checking bench for ioctl_tx. A rule-level reference model
// predicts, per cycle, the download envelope, ready/write/done pulses and the
// address/data stream; directed scenarios add latency, spacing and reset checks.
// Optional feature macro: IOCTL_TX_CHECKSUM_EN
module tb_ioctl_tx;
   import ioctl_pkg::*;

   localparam int ADDR_W   = 25;
   localparam int WR_GAP   = 3;
   localparam int LEAD_CYC = 2;
   localparam int TAIL_CYC = 4;
   localparam int BIG      = 32'h3fff_ffff;

   logic              clk_sys = 1'b0;
   logic              reset, start, src_valid, src_ready, busy, done;
   logic [7:0]        index, src_data;
   logic [ADDR_W-1:0] length;
`ifdef IOCTL_TX_CHECKSUM_EN
   logic [7:0]        checksum;
`endif

   ioctl_tx_if #(.ADDR_W(ADDR_W)) io();

   ioctl_tx #(.ADDR_W(ADDR_W), .WR_GAP(WR_GAP), .LEAD_CYC(LEAD_CYC), .TAIL_CYC(TAIL_CYC)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .start     (start),
      .index     (index),
      .length    (length),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .busy      (busy),
      .done      (done),
      .io        (io)
`ifdef IOCTL_TX_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int checks = 0, errors = 0, cyc = 0;
   logic [7:0] img [64];

   // reference model: transfer described by its rules, not by FSM states
   bit         xon, pend;
   int         t_start, len_m, nwr, nhs, hs_cyc, fetch_from, end_cyc;
   logic [7:0] idx_m, sum_m;
   // observed activity of the current transfer
   int         wr_obs, done_obs, dl_obs, done_at;
   int         wr_at [64];
   // stimulus knobs
   int         vpct = 100, wpct = 0, w_lo = 1, w_hi = 0, nv_lo = 1, nv_hi = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      bit e_dl, e_done, e_wr, e_rdy;
      #1;
      e_dl   = xon && (cyc > t_start) && (cyc <= end_cyc);
      e_done = xon && (cyc == end_cyc + 1);
      e_wr   = xon && (cyc == hs_cyc + 1);
      e_rdy  = e_dl && !pend && (nwr < len_m) && (cyc >= fetch_from) &&
               src_valid && !io.ioctl_wait;

      chk("download", io.ioctl_download, e_dl);
      chk("busy", busy, e_dl);
      chk("wr", io.ioctl_wr, e_wr);
      chk("src_ready", src_ready, e_rdy);
      chk("done", done, e_done);
      if (e_dl) chk("index", io.ioctl_index, idx_m);
      if (e_wr) begin
         chk("wr_addr", io.ioctl_addr, nwr);
         chk("wr_dout", io.ioctl_dout, img[nwr]);
      end else if (e_dl && nwr > 0) begin
         chk("hold_addr", io.ioctl_addr, nwr - 1);
         chk("hold_dout", io.ioctl_dout, img[nwr-1]);
      end
`ifdef IOCTL_TX_CHECKSUM_EN
      if (e_done) chk("checksum_at_done", checksum, sum_m);
`endif

      if (io.ioctl_wr === 1'b1 && wr_obs < 64) begin wr_at[wr_obs] = cyc; wr_obs++; end
      if (done === 1'b1) begin done_obs++; done_at = cyc; end
      if (io.ioctl_download === 1'b1) dl_obs++;

      if (e_rdy) begin hs_cyc = cyc; pend = 1; nhs++; end
      if (e_wr) begin
         sum_m = sum_m + img[nwr];
         nwr++;
         pend = 0;
         fetch_from = cyc + 1 + WR_GAP;
         if (nwr == len_m) end_cyc = cyc + WR_GAP + TAIL_CYC;
      end
      if (e_done) xon = 0;
      if (reset) begin
         xon = 0; pend = 0;
      end else if (start && !xon) begin
         xon = 1; t_start = cyc; len_m = int'(length); idx_m = index;
         nwr = 0; nhs = 0; pend = 0; hs_cyc = -100; sum_m = 8'd0;
         fetch_from = cyc + 1 + LEAD_CYC;
         end_cyc = (length == '0) ? cyc + LEAD_CYC + TAIL_CYC : BIG;
         wr_obs = 0; done_obs = 0; dl_obs = 0;
      end
      @(posedge clk_sys); #1;
      cyc++;
   endtask

   task automatic drive(input bit st);
      start         = st;
      src_valid     = ($urandom_range(99) < vpct) && !(cyc >= nv_lo && cyc <= nv_hi);
      src_data      = src_valid ? img[nhs % 64] : 8'($urandom);
      io.ioctl_wait = ($urandom_range(99) < wpct) || (cyc >= w_lo && cyc <= w_hi);
      tick();
   endtask

   task automatic start_xfer(input int len, input logic [7:0] idx);
      length = ADDR_W'(len);
      index  = idx;
      drive(1'b1);
      start  = 1'b0;
   endtask

   task automatic run_idle(input int bound);
      for (int k = 0; k < bound && xon; k++) drive(1'b0);
      chk("transfer_timeout", xon, 0);
   endtask

   task automatic fill_rand(input int len);
      for (int i = 0; i < len; i++) img[i] = 8'($urandom);
   endtask

   initial begin
      int t0, len;
      reset = 1'b1; start = 1'b0; index = '0; length = '0;
      src_valid = 1'b0; src_data = '0; io.ioctl_wait = 1'b0;
      xon = 0; pend = 0; hs_cyc = -100; end_cyc = BIG; t_start = 0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_download", io.ioctl_download, 0);
      chk("rst_wr", io.ioctl_wr, 0);
      chk("rst_addr", io.ioctl_addr, 0);
      chk("rst_dout", io.ioctl_dout, 0);
      chk("rst_index", io.ioctl_index, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      repeat (2) drive(1'b0);

      // basic transfer
      img[0] = 8'hA0; img[1] = 8'hA1; img[2] = 8'hA2; img[3] = 8'hA3;
      t0 = cyc;
      start_xfer(4, IOCTL_IDX_CART);
      run_idle(100);
      chk("basic_wr_count", wr_obs, 4);
      chk("basic_first_wr_lat", wr_at[0] - t0, 1 + LEAD_CYC + 1);
      for (int i = 1; i < 4; i++) chk("basic_wr_spacing", wr_at[i] - wr_at[i-1], 2 + WR_GAP);
      chk("basic_done_after_last_wr", done_at - wr_at[3], WR_GAP + TAIL_CYC + 1);
      chk("basic_done_count", done_obs, 1);
      repeat (2) drive(1'b0);

      // wait back-pressure held for 10 cycles from the fetch of byte 1
      fill_rand(3);
      start_xfer(3, IOCTL_IDX_BIOS);
      for (int k = 0; k < 50 && nwr < 1; k++) drive(1'b0);
      w_lo = fetch_from; w_hi = fetch_from + 9;
      run_idle(100);
      chk("wait_byte1_time", wr_at[1], w_hi + 2);
      chk("wait_wr_count", wr_obs, 3);
      w_lo = 1; w_hi = 0;
      repeat (2) drive(1'b0);

      // source stall of 7 cycles before byte 2
      fill_rand(3);
      start_xfer(3, 8'h5A);
      for (int k = 0; k < 50 && nwr < 2; k++) drive(1'b0);
      nv_lo = fetch_from; nv_hi = fetch_from + 6;
      run_idle(100);
      chk("stall_byte2_time", wr_at[2], nv_hi + 2);
      chk("stall_wr_count", wr_obs, 3);
      nv_lo = 1; nv_hi = 0;
      repeat (2) drive(1'b0);

      // zero-length transfer
      start_xfer(0, IOCTL_IDX_BIOS);
      run_idle(50);
      chk("len0_download_cycles", dl_obs, LEAD_CYC + TAIL_CYC);
      chk("len0_wr_count", wr_obs, 0);
      chk("len0_done_count", done_obs, 1);
      repeat (2) drive(1'b0);

      // start during busy is ignored
      fill_rand(5);
      start_xfer(5, IOCTL_IDX_CART);
      repeat (7) drive(1'b0);
      length = ADDR_W'(9);
      drive(1'b1);
      start = 1'b0;
      run_idle(100);
      chk("restart_wr_count", wr_obs, 5);
      chk("restart_done_count", done_obs, 1);
      repeat (2) drive(1'b0);

      // reset at byte 2, then a fresh full transfer
      fill_rand(5);
      start_xfer(5, 8'h33);
      for (int k = 0; k < 50 && nwr < 2; k++) drive(1'b0);
      reset = 1'b1;
      drive(1'b0);
      reset = 1'b0;
      chk("midrst_download", io.ioctl_download, 0);
      chk("midrst_wr", io.ioctl_wr, 0);
      chk("midrst_addr", io.ioctl_addr, 0);
      chk("midrst_dout", io.ioctl_dout, 0);
      chk("midrst_index", io.ioctl_index, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      repeat (20) drive(1'b0);
      chk("midrst_no_done", done_obs, 0);
      fill_rand(4);
      start_xfer(4, IOCTL_IDX_CART);
      run_idle(100);
      chk("fresh_wr_count", wr_obs, 4);
      chk("fresh_done_count", done_obs, 1);
      repeat (2) drive(1'b0);

      // randomized transfers with random valid/wait and stray starts while busy
      for (int n = 0; n < 6; n++) begin
         len  = int'($urandom_range(1, 10));
         fill_rand(len);
         vpct = int'($urandom_range(50, 100));
         wpct = int'($urandom_range(0, 30));
         start_xfer(len, 8'($urandom));
         for (int k = 0; k < 600 && xon; k++)
            drive(($urandom_range(19) == 0) && (cyc < end_cyc));
         chk("rand_transfer_timeout", xon, 0);
         chk("rand_wr_count", wr_obs, len);
         chk("rand_done_count", done_obs, 1);
         vpct = 100; wpct = 0;
         repeat (2) drive(1'b0);
      end

`ifdef IOCTL_TX_CHECKSUM_EN
      img[0] = 8'hFF; img[1] = 8'h02; img[2] = 8'h10;
      start_xfer(3, IOCTL_IDX_BIOS);
      run_idle(100);
      chk("checksum_ff0210", checksum, 8'h11);
      drive(1'b0);
      chk("checksum_stable", checksum, 8'h11);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
